// File: rtl/reset_sequencer.sv
// Multi-channel power-on reset sequencer: waits for clock lock, holds all domains for a
// common time, then releases them in index order with per-channel delays.
module reset_sequencer #(
  parameter int                   NUM_CH      = 3,
  parameter int                   CLKS_PER_MS = 54000,
  parameter int                   INIT_MS     = 50,
  parameter logic [NUM_CH*16-1:0] DELAY_MS    = {16'd10, 16'd0, 16'd0}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lock_i,
  input  logic              sw_rst_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              done_o,
  output logic [1:0]        state_o,
  output logic [3:0]        ch_o
);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_STEP      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam longint      INIT_PROD = longint'(INIT_MS) * longint'(CLKS_PER_MS);
  localparam logic [31:0] INIT_CYC  = (INIT_PROD == 64'sd0) ? 32'd1 : 32'(INIT_PROD);

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH must be in 1..16");
  end
  if (INIT_PROD >= 64'sh1_0000_0000) begin : g_bad_init
    $error("reset_sequencer: INIT_MS * CLKS_PER_MS does not fit in 32 bits");
  end

  // Per-channel step lengths; unused slots are padded so a 4-bit index is always legal.
  logic [31:0] w_len [16];
  for (genvar k = 0; k < 16; k++) begin : g_len
    if (k < NUM_CH) begin : g_used
      localparam longint PROD = longint'(DELAY_MS[16*k +: 16]) * longint'(CLKS_PER_MS);
      if (PROD >= 64'sh1_0000_0000) begin : g_bad_delay
        $error("reset_sequencer: DELAY_MS field * CLKS_PER_MS does not fit in 32 bits");
      end
      assign w_len[k] = (PROD == 64'sd0) ? 32'd1 : 32'(PROD);
    end else begin : g_unused
      assign w_len[k] = 32'd1;
    end
  end

  logic              r_lock_meta;
  logic              r_lock_s;
  state_t            r_state;
  logic [3:0]        r_ch;
  logic [31:0]       r_cnt;
  logic [NUM_CH-1:0] r_rst;
  logic              r_done;

  state_t            w_state_nxt;
  logic [3:0]        w_ch_nxt;
  logic [31:0]       w_cnt_nxt;
  logic [NUM_CH-1:0] w_rst_nxt;
  logic              w_done_nxt;

  // State, counter, output and lock-synchroniser registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= S_WAIT_LOCK;
      r_ch        <= 4'd0;
      r_cnt       <= 32'd0;
      r_rst       <= {NUM_CH{1'b1}};
      r_done      <= 1'b0;
    end else begin
      r_lock_meta <= lock_i;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state_nxt;
      r_ch        <= w_ch_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rst       <= w_rst_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state logic: normal sequencing first, then lock loss / re-trigger overrides.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt + 32'd1;
    w_rst_nxt   = r_rst;
    w_done_nxt  = r_done;

    case (r_state)
      S_WAIT_LOCK: begin
        w_rst_nxt  = {NUM_CH{1'b1}};
        w_done_nxt = 1'b0;
        w_ch_nxt   = 4'd0;
        if (r_lock_s) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 32'd0;
        end else begin
          w_state_nxt = S_WAIT_LOCK;
        end
      end
      S_HOLD: begin
        w_rst_nxt = {NUM_CH{1'b1}};
        if (r_cnt == INIT_CYC - 32'd1) begin
          w_state_nxt = S_STEP;
          w_ch_nxt    = 4'd0;
          w_cnt_nxt   = 32'd0;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_STEP: begin
        if (r_cnt == w_len[r_ch] - 32'd1) begin
          for (int k = 0; k < NUM_CH; k++) begin
            w_rst_nxt[k] = r_rst[k] & (4'(k) != r_ch);
          end
          w_cnt_nxt = 32'd0;
          if (r_ch == 4'(NUM_CH - 1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_ch_nxt    = 4'd0;
          end else begin
            w_ch_nxt = r_ch + 4'd1;
          end
        end else begin
          w_state_nxt = S_STEP;
        end
      end
      S_DONE: begin
        w_rst_nxt  = {NUM_CH{1'b0}};
        w_done_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_rst_nxt   = {NUM_CH{1'b1}};
        w_done_nxt  = 1'b0;
        w_ch_nxt    = 4'd0;
        w_cnt_nxt   = 32'd0;
      end
    endcase

    if ((r_state != S_WAIT_LOCK) && !r_lock_s) begin
      w_state_nxt = S_WAIT_LOCK;
      w_rst_nxt   = {NUM_CH{1'b1}};
      w_done_nxt  = 1'b0;
      w_ch_nxt    = 4'd0;
      w_cnt_nxt   = 32'd0;
    end else if ((r_state != S_WAIT_LOCK) && sw_rst_i) begin
      w_state_nxt = S_HOLD;
      w_rst_nxt   = {NUM_CH{1'b1}};
      w_done_nxt  = 1'b0;
      w_ch_nxt    = 4'd0;
      w_cnt_nxt   = 32'd0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  assign rst_o   = r_rst;
  assign rst_n_o = ~r_rst;
  assign done_o  = r_done;
  assign state_o = r_state;
  assign ch_o    = r_ch;

endmodule
